// File: rtl/cu_dealloc_arbiter_pkg.sv
// Shared dispatcher definitions: dealloc FSM encoding, default widths and
// the round-robin pointer advance helper.
package cu_dealloc_arbiter_pkg;

   localparam int DEF_NUMBER_CU   = 32'sd2;
   localparam int DEF_CU_ID_WIDTH = 32'sd2;
   localparam int DEF_WG_ID_WIDTH = 32'sd8;
   localparam int DEF_WAIT_LIMIT  = 32'sd1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_WAIT  = 2'd2
   } dealloc_state_e;

   // Index following idx in a ring of n entries (last entry wraps to 0).
   function automatic int rr_advance(input int idx, input int n);
      return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
   endfunction

endpackage

// File: rtl/cu_dealloc_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at an index >= ptr, otherwise
// the lowest set bit (wrap-around). Purely combinational.
module cu_dealloc_arbiter_rr_pick
   import cu_dealloc_arbiter_pkg::*;
#(
   parameter int N     = DEF_NUMBER_CU,
   parameter int IDX_W = DEF_CU_ID_WIDTH
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic             hi_found_s;
   logic [IDX_W-1:0] hi_idx_s;
   logic             lo_found_s;
   logic [IDX_W-1:0] lo_idx_s;

   // Scan downwards so the lowest qualifying index is the one left standing.
   always_comb begin
      hi_found_s = 1'b0;
      hi_idx_s   = '0;
      lo_found_s = 1'b0;
      lo_idx_s   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         hi_found_s = hi_found_s | (req[i] & (IDX_W'(i) >= ptr));
         hi_idx_s   = (req[i] && (IDX_W'(i) >= ptr)) ? IDX_W'(i) : hi_idx_s;
         lo_found_s = lo_found_s | req[i];
         lo_idx_s   = req[i] ? IDX_W'(i) : lo_idx_s;
      end
   end

   assign found = lo_found_s;
   assign idx   = hi_found_s ? hi_idx_s : lo_idx_s;

endmodule

// File: rtl/cu_dealloc_arbiter.sv
// Workgroup dealloc arbiter: one done-slot per CU, round-robin offer to the
// dispatch controller, then wait for the resource table to confirm the
// dealloc of that CU. A sticky watchdog flags a confirmation that never comes.
module cu_dealloc_arbiter
   import cu_dealloc_arbiter_pkg::*;
#(
   parameter int NUMBER_CU   = DEF_NUMBER_CU,
   parameter int CU_ID_WIDTH = DEF_CU_ID_WIDTH,
   parameter int WG_ID_WIDTH = DEF_WG_ID_WIDTH,
   parameter int WAIT_LIMIT  = DEF_WAIT_LIMIT
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUMBER_CU-1:0]             cu_wg_done_valid_i,
   input  logic [NUMBER_CU*WG_ID_WIDTH-1:0] cu_wg_done_wg_id_i,
   output logic [NUMBER_CU-1:0]             cu_wg_done_ready_o,
   output logic                             dealloc_available_o,
   output logic [CU_ID_WIDTH-1:0]           dealloc_cu_id_o,
   output logic [WG_ID_WIDTH-1:0]           dealloc_wg_id_o,
   input  logic                             dis_controller_wg_dealloc_valid_i,
   input  logic                             grt_wg_dealloc_done_i,
   input  logic [CU_ID_WIDTH-1:0]           grt_wg_dealloc_cu_id_i,
   output logic                             dealloc_timeout_o
);

   localparam int               CNT_W   = $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WAIT_LIMIT);

   dealloc_state_e         state_r;
   dealloc_state_e         state_next_s;
   logic [NUMBER_CU-1:0]   slot_valid_r;
   logic [WG_ID_WIDTH-1:0] slot_wg_r [NUMBER_CU];
   logic [CU_ID_WIDTH-1:0] rr_ptr_r;
   logic [CU_ID_WIDTH-1:0] grant_idx_r;
   logic [WG_ID_WIDTH-1:0] grant_wg_r;
   logic [CNT_W-1:0]       wait_cnt_r;
   logic [CNT_W-1:0]       wait_cnt_next_s;
   logic                   timeout_r;

   logic                   pick_found_s;
   logic [CU_ID_WIDTH-1:0] pick_idx_s;
   logic [WG_ID_WIDTH-1:0] pick_wg_s;
   logic                   grant_s;
   logic                   accept_s;
   logic [NUMBER_CU-1:0]   capture_s;
   logic [NUMBER_CU-1:0]   clear_s;

   cu_dealloc_arbiter_rr_pick #(
      .N     (NUMBER_CU),
      .IDX_W (CU_ID_WIDTH)
   ) u_rr_pick (
      .req   (slot_valid_r),
      .ptr   (rr_ptr_r),
      .found (pick_found_s),
      .idx   (pick_idx_s)
   );

   // FSM next-state and one-cycle action strobes.
   always_comb begin
      state_next_s = state_r;
      grant_s      = 1'b0;
      accept_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_found_s) begin
               state_next_s = ST_OFFER;
               grant_s      = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_OFFER: begin
            if (dis_controller_wg_dealloc_valid_i) begin
               state_next_s = ST_WAIT;
               accept_s     = 1'b1;
            end else begin
               state_next_s = ST_OFFER;
            end
         end
         ST_WAIT: begin
            // Only the confirmation for the CU we handed out releases us.
            if (grt_wg_dealloc_done_i && (grt_wg_dealloc_cu_id_i == grant_idx_r)) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Per-slot capture/clear masks and the wg id of the slot being picked.
   always_comb begin
      capture_s = cu_wg_done_valid_i & ~slot_valid_r;
      clear_s   = '0;
      pick_wg_s = '0;
      for (int i = 0; i < NUMBER_CU; i++) begin
         clear_s[i] = accept_s & (grant_idx_r == CU_ID_WIDTH'(i));
         pick_wg_s  = (pick_idx_s == CU_ID_WIDTH'(i)) ? slot_wg_r[i] : pick_wg_s;
      end
   end

   // Saturating watchdog count while waiting for the resource table.
   always_comb begin
      if (state_r == ST_WAIT) begin
         wait_cnt_next_s = (wait_cnt_r == LIMIT_C) ? LIMIT_C : (wait_cnt_r + CNT_W'(1'b1));
      end else begin
         wait_cnt_next_s = wait_cnt_r;
      end
   end

   // Slot storage; a slot is only cleared while valid and only captured while
   // free, so the two never target the same slot in one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_valid_r <= '0;
         for (int i = 0; i < NUMBER_CU; i++) begin
            slot_wg_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUMBER_CU; i++) begin
            if (clear_s[i]) begin
               slot_valid_r[i] <= 1'b0;
            end else if (capture_s[i]) begin
               slot_valid_r[i] <= 1'b1;
               slot_wg_r[i]    <= cu_wg_done_wg_id_i[i*WG_ID_WIDTH +: WG_ID_WIDTH];
            end else begin
               slot_valid_r[i] <= slot_valid_r[i];
            end
         end
      end
   end

   // FSM state, grant latch, round-robin pointer and watchdog.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         grant_idx_r <= '0;
         grant_wg_r  <= '0;
         rr_ptr_r    <= '0;
         wait_cnt_r  <= '0;
         timeout_r   <= 1'b0;
      end else begin
         state_r <= state_next_s;
         // The wg id is copied at grant time so the slot may refill while we wait.
         if (grant_s) begin
            grant_idx_r <= pick_idx_s;
            grant_wg_r  <= pick_wg_s;
         end
         if (accept_s) begin
            rr_ptr_r   <= CU_ID_WIDTH'(rr_advance(int'(grant_idx_r), NUMBER_CU));
            wait_cnt_r <= '0;
         end else begin
            wait_cnt_r <= wait_cnt_next_s;
         end
         if ((state_r == ST_WAIT) && (wait_cnt_next_s == LIMIT_C)) begin
            timeout_r <= 1'b1;
         end
      end
   end

   assign cu_wg_done_ready_o  = ~slot_valid_r;
   assign dealloc_available_o = (state_r == ST_OFFER);
   assign dealloc_cu_id_o     = grant_idx_r;
   assign dealloc_wg_id_o     = grant_wg_r;
   assign dealloc_timeout_o   = timeout_r;

endmodule

// File: tb/tb_cu_dealloc_arbiter.sv
// Self-checking bench for cu_dealloc_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of slots, offer/wait phases and the watchdog.
module tb_cu_dealloc_arbiter;

   localparam int N  = 2;
   localparam int CW = 2;
   localparam int WW = 8;
   localparam int WL = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    v;
   logic [N*WW-1:0] wg;
   logic [N-1:0]    ready;
   logic            avail;
   logic [CW-1:0]   cu_id;
   logic [WW-1:0]   wg_id;
   logic            acc;
   logic            done;
   logic [CW-1:0]   done_id;
   logic            tmo;

   always #5 clk = ~clk;

   cu_dealloc_arbiter #(
      .NUMBER_CU   (N),
      .CU_ID_WIDTH (CW),
      .WG_ID_WIDTH (WW),
      .WAIT_LIMIT  (WL)
   ) dut (
      .clk                               (clk),
      .rst_n                             (rst_n),
      .cu_wg_done_valid_i                (v),
      .cu_wg_done_wg_id_i                (wg),
      .cu_wg_done_ready_o                (ready),
      .dealloc_available_o               (avail),
      .dealloc_cu_id_o                   (cu_id),
      .dealloc_wg_id_o                   (wg_id),
      .dis_controller_wg_dealloc_valid_i (acc),
      .grt_wg_dealloc_done_i             (done),
      .grt_wg_dealloc_cu_id_i            (done_id),
      .dealloc_timeout_o                 (tmo)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = idle, 1 = offering, 2 = waiting for table confirmation
   bit         m_pend [N];
   logic [7:0] m_pwg  [N];
   int         m_phase;
   int         m_gidx;
   logic [7:0] m_gwg;
   int         m_ptr;
   int         m_cnt;
   bit         m_to;
   bit         m_live = 1'b0;

   function automatic logic [N-1:0] exp_ready();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = !m_pend[i];
      return r;
   endfunction

   task automatic model_step();
      bit cap [N];
      bit hit;
      int j;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_pwg[i]  = 8'h00;
         end
         m_phase = 0; m_gidx = 0; m_gwg = 8'h00; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
         m_live = 1'b1;
      end else begin
         for (int i = 0; i < N; i++) cap[i] = v[i] && !m_pend[i];
         if (m_phase == 0) begin
            hit = 1'b0;
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (!hit && m_pend[j]) begin
                  hit = 1'b1; m_gidx = j; m_gwg = m_pwg[j]; m_phase = 1;
               end
            end
         end else if (m_phase == 1) begin
            if (acc) begin
               m_pend[m_gidx] = 1'b0;
               m_ptr   = (m_gidx + 1) % N;
               m_cnt   = 0;
               m_phase = 2;
            end
         end else begin
            m_cnt = (m_cnt + 1 > WL) ? WL : m_cnt + 1;
            if (m_cnt >= WL) m_to = 1'b1;
            if (done && int'(done_id) == m_gidx) m_phase = 0;
         end
         for (int i = 0; i < N; i++) begin
            if (cap[i]) begin
               m_pend[i] = 1'b1;
               m_pwg[i]  = wg[i*WW +: WW];
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (m_live) begin
         chk("ready",     32'(ready), 32'(exp_ready()));
         chk("available", 32'(avail), 32'(m_phase == 1));
         chk("cu_id",     32'(cu_id), 32'(m_gidx));
         chk("wg_id",     32'(wg_id), 32'(m_gwg));
         chk("timeout",   32'(tmo),   32'(m_to));
      end
   end

   // ---------------- driver helpers ----------------
   task automatic lit(input string nm, input logic [31:0] dut_v, input logic [31:0] mod_v,
                      input logic [31:0] exp);
      chk({nm, "_dut"},   dut_v, exp);
      chk({nm, "_model"}, mod_v, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_in();
      v = '0; wg = '0; acc = 1'b0; done = 1'b0; done_id = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_in();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_in();
      do_reset();

      // Reset values
      sample();
      lit("rst_ready", 32'(ready), 32'(exp_ready()), 32'h3);
      lit("rst_avail", 32'(avail), 32'(m_phase == 1), 32'h0);
      lit("rst_cu",    32'(cu_id), 32'(m_gidx), 32'h0);
      lit("rst_wg",    32'(wg_id), 32'(m_gwg), 32'h0);
      lit("rst_tmo",   32'(tmo),   32'(m_to), 32'h0);

      // Single request from CU1, two-cycle latency, accept frees the slot
      v = 2'b10; wg = {8'h2A, 8'h00};
      tick(); v = '0;
      sample(); lit("lat_c1_avail", 32'(avail), 32'(m_phase == 1), 32'h0);
      tick();
      sample();
      lit("single_avail", 32'(avail), 32'(m_phase == 1), 32'h1);
      lit("single_cu",    32'(cu_id), 32'(m_gidx), 32'h1);
      lit("single_wg",    32'(wg_id), 32'(m_gwg), 32'h2A);
      lit("single_ready", 32'(ready), 32'(exp_ready()), 32'h1);
      tick(); tick(); acc = 1'b1;
      tick(); acc = 1'b0;
      sample();
      lit("accept_avail", 32'(avail), 32'(m_phase == 1), 32'h0);
      lit("accept_ready", 32'(ready), 32'(exp_ready()), 32'h3);

      // Waiting for CU1: a done for CU0 is ignored, CU1's done releases
      done = 1'b1; done_id = 2'd0; v = 2'b01; wg = {8'h00, 8'h11};
      tick(); done = 1'b0; v = '0;
      tick(); tick();
      sample(); lit("wrongid_avail", 32'(avail), 32'(m_phase == 1), 32'h0);
      done = 1'b1; done_id = 2'd1;
      tick(); done = 1'b0;
      sample(); lit("rightid_idle_avail", 32'(avail), 32'(m_phase == 1), 32'h0);
      tick();
      sample();
      lit("after_done_avail", 32'(avail), 32'(m_phase == 1), 32'h1);
      lit("after_done_cu",    32'(cu_id), 32'(m_gidx), 32'h0);
      lit("after_done_wg",    32'(wg_id), 32'(m_gwg), 32'h11);
      lit("short_wait_tmo",   32'(tmo),   32'(m_to), 32'h0);

      // Watchdog: eight waiting cycles with no done
      acc = 1'b1;
      tick(); acc = 1'b0;
      repeat (7) tick();
      sample(); lit("wd_before", 32'(tmo), 32'(m_to), 32'h0);
      tick();
      sample(); lit("wd_fire", 32'(tmo), 32'(m_to), 32'h1);
      done = 1'b1; done_id = 2'd0;
      tick(); done = 1'b0;
      tick();
      sample(); lit("wd_sticky", 32'(tmo), 32'(m_to), 32'h1);
      do_reset();
      sample(); lit("wd_reset", 32'(tmo), 32'(m_to), 32'h0);

      // Contention: CU0 first, then CU1, pointer wraps back to 0
      v = 2'b11; wg = {8'hB1, 8'hA0};
      tick(); v = '0;
      tick();
      sample();
      lit("cont1_cu", 32'(cu_id), 32'(m_gidx), 32'h0);
      lit("cont1_wg", 32'(wg_id), 32'(m_gwg), 32'hA0);
      acc = 1'b1;
      tick(); acc = 1'b0; done = 1'b1; done_id = 2'd0;
      tick(); done = 1'b0;
      tick();
      sample();
      lit("cont2_avail", 32'(avail), 32'(m_phase == 1), 32'h1);
      lit("cont2_cu",    32'(cu_id), 32'(m_gidx), 32'h1);
      lit("cont2_wg",    32'(wg_id), 32'(m_gwg), 32'hB1);
      acc = 1'b1;
      tick(); acc = 1'b0; done = 1'b1; done_id = 2'd1;
      tick(); done = 1'b0;
      v = 2'b11; wg = {8'hB2, 8'hA2};
      tick(); v = '0;
      tick();
      sample();
      lit("rr_wrap_cu", 32'(cu_id), 32'(m_gidx), 32'h0);
      lit("rr_wrap_wg", 32'(wg_id), 32'(m_gwg), 32'hA2);

      // Reset while offering with both slots full
      rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      sample();
      lit("rst_offer_avail", 32'(avail), 32'(m_phase == 1), 32'h0);
      lit("rst_offer_ready", 32'(ready), 32'(exp_ready()), 32'h3);
      repeat (3) tick();
      sample(); lit("no_offer_after_rst", 32'(avail), 32'(m_phase == 1), 32'h0);

      // Backpressure: CU0 holds valid while its slot is full
      v = 2'b01; wg = {8'h00, 8'h01};
      tick(); wg = {8'h00, 8'h02};
      sample(); lit("bp_ready_full", 32'(ready), 32'(exp_ready()), 32'h2);
      tick();
      sample(); lit("bp_first_wg", 32'(wg_id), 32'(m_gwg), 32'h01);
      acc = 1'b1;
      tick(); acc = 1'b0;
      sample(); lit("bp_ready_freed", 32'(ready), 32'(exp_ready()), 32'h3);
      done = 1'b1; done_id = 2'd0;
      tick(); done = 1'b0; v = '0;
      sample(); lit("bp_recaptured", 32'(ready), 32'(exp_ready()), 32'h2);
      tick();
      sample();
      lit("bp_second_avail", 32'(avail), 32'(m_phase == 1), 32'h1);
      lit("bp_second_wg",    32'(wg_id), 32'(m_gwg), 32'h02);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst_n   = ($urandom_range(0, 249) != 0);
         v       = 2'($urandom());
         wg      = 16'($urandom());
         acc     = ($urandom_range(0, 2) == 0);
         done    = ($urandom_range(0, 3) == 0);
         done_id = 2'($urandom());
         tick();
      end
      idle_in();
      rst_n = 1'b1;
      tick();
      sample();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
